// File: rtl/cache4way_miss_handler_pkg.sv
// Shared definitions for the 4-way cache miss handler and its SRAM-like
// front end: geometry constants, FSM encoding and pseudo-LRU helpers.
package cache4way_miss_handler_pkg;

    localparam int BLKIDX_BIT = 4;
    localparam int WRDIDX_BIT = 4;
    localparam int TAG_BIT    = 32 - 2 - WRDIDX_BIT - BLKIDX_BIT;
    localparam int LINE_WORDS = 1 << WRDIDX_BIT;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_REFILL = 3'd3,
        ST_META   = 3'd4,
        ST_DONE   = 3'd5,
        ST_UNC    = 3'd6
    } mh_state_t;

    // Victim choice: lowest invalid way first, otherwise follow the PLRU tree.
    // history[0]=1 points at the lower pair (history[1] picks way0/way1),
    // history[0]=0 points at the upper pair (history[2] picks way2/way3).
    function automatic logic [3:0] plru_decode(input logic [3:0] valid,
                                               input logic [2:0] history);
        logic [3:0] victim;
        victim = 4'b0000;
        if (!valid[0]) begin
            victim = 4'b0001;
        end else if (!valid[1]) begin
            victim = 4'b0010;
        end else if (!valid[2]) begin
            victim = 4'b0100;
        end else if (!valid[3]) begin
            victim = 4'b1000;
        end else if (history[0]) begin
            victim = history[1] ? 4'b0001 : 4'b0010;
        end else begin
            victim = history[2] ? 4'b0100 : 4'b1000;
        end
        return victim;
    endfunction

    // History after touching one way: point the tree away from that way.
    function automatic logic [2:0] plru_update(input logic [2:0] history,
                                               input logic [3:0] way);
        logic [2:0] upd;
        case (way)
            4'b1000: upd = {1'b1, history[1], 1'b1};
            4'b0100: upd = {1'b0, history[1], 1'b1};
            4'b0010: upd = {history[2], 1'b1, 1'b0};
            4'b0001: upd = {history[2], 2'b00};
            default: upd = history;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/cache4way_miss_handler_plru4_victim.sv
// Combinational victim selector for one 4-way set.
module plru4_victim
    import cache4way_miss_handler_pkg::*;
(
    input  logic [3:0] valid,
    input  logic [2:0] history,
    output logic [3:0] victim
);

    assign victim = plru_decode(valid, history);

endmodule

// File: rtl/cache4way_miss_handler.sv
// Miss handler: victim selection, dirty write-back, line refill and
// metadata install for cached misses; single-word uncached accesses.
module cache4way_miss_handler
    import cache4way_miss_handler_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    handler_req,
    input  logic                    handler_cached,
    input  logic                    handler_w,
    input  logic [31:0]             handler_paddr,
    input  logic [BLKIDX_BIT-1:0]   handler_blkidx,
    input  logic [31:0]             handler_wdata,
    input  logic [3:0]              handler_wen,
    output logic                    handler_fin,
    output logic [31:0]             handler_rdata,
    output logic [BLKIDX_BIT-1:0]   mh_blkidx,
    output logic [WRDIDX_BIT-1:0]   mh_wrdidx,
    output logic [127:0]            mh_wdata,
    output logic [15:0]             mh_wen,
    input  logic [127:0]            cache_rdata,
    input  logic [4*TAG_BIT-1:0]    cache_tag_r,
    input  logic [3:0]              cache_valid_r,
    input  logic [3:0]              cache_dirty_r,
    input  logic [2:0]              cache_history_r,
    output logic [3:0]              mh_wen_tag,
    output logic [3:0]              mh_wen_valid,
    output logic [3:0]              mh_wen_dirty,
    output logic [4*TAG_BIT-1:0]    mh_tag_w,
    output logic [3:0]              mh_valid_w,
    output logic [3:0]              mh_dirty_w,
    output logic                    mh_wen_history,
    output logic [2:0]              mh_history_w,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_wstrb,
    input  logic                    mem_ack,
    input  logic [31:0]             mem_rdata
);

    localparam logic [WRDIDX_BIT-1:0] CNT_ZERO = {WRDIDX_BIT{1'b0}};
    localparam logic [WRDIDX_BIT-1:0] CNT_ONE  = {{(WRDIDX_BIT-1){1'b0}}, 1'b1};
    localparam logic [WRDIDX_BIT-1:0] CNT_LAST = {WRDIDX_BIT{1'b1}};

    mh_state_t               state_r, state_s;
    logic [WRDIDX_BIT-1:0]   cnt_r, cnt_s;
    logic [31:0]             paddr_r;
    logic [BLKIDX_BIT-1:0]   blkidx_r;
    logic [31:0]             wdata_r;
    logic [3:0]              wen_r;
    logic                    w_r;
    logic [3:0]              victim_r;
    logic [TAG_BIT-1:0]      vtag_r;
    logic [31:0]             rdata_r;

    logic [3:0]              victim_s;
    logic [TAG_BIT-1:0]      vtag_s;
    logic                    vdirty_s;
    logic [31:0]             wb_word_s;

    plru4_victim u_victim (
        .valid   (cache_valid_r),
        .history (cache_history_r),
        .victim  (victim_s)
    );

    assign handler_rdata = rdata_r;

    // Tag and dirtiness of the way chosen during lookup.
    always_comb begin
        vtag_s = {TAG_BIT{1'b0}};
        for (int i = 0; i < 4; i++) begin
            vtag_s = vtag_s | (victim_s[i] ? cache_tag_r[i*TAG_BIT +: TAG_BIT]
                                           : {TAG_BIT{1'b0}});
        end
        vdirty_s = |(victim_s & cache_valid_r & cache_dirty_r);
    end

    // Word of the latched victim way being written back.
    always_comb begin
        wb_word_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            wb_word_s = wb_word_s | (victim_r[i] ? cache_rdata[i*32 +: 32] : 32'h0000_0000);
        end
    end

    // State and word counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture, victim capture and uncached read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_r  <= 32'h0000_0000;
            blkidx_r <= {BLKIDX_BIT{1'b0}};
            wdata_r  <= 32'h0000_0000;
            wen_r    <= 4'h0;
            w_r      <= 1'b0;
            victim_r <= 4'h0;
            vtag_r   <= {TAG_BIT{1'b0}};
            rdata_r  <= 32'h0000_0000;
        end else begin
            if (state_r == ST_IDLE && handler_req) begin
                paddr_r  <= handler_paddr;
                blkidx_r <= handler_blkidx;
                wdata_r  <= handler_wdata;
                wen_r    <= handler_wen;
                w_r      <= handler_w;
            end
            if (state_r == ST_LOOKUP) begin
                victim_r <= victim_s;
                vtag_r   <= vtag_s;
            end
            if (state_r == ST_UNC && mem_ack && !w_r) begin
                rdata_r <= mem_rdata;
            end
        end
    end

    // Next-state, counter and all array/memory port outputs.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        handler_fin    = 1'b0;
        mh_blkidx      = {BLKIDX_BIT{1'b0}};
        mh_wrdidx      = CNT_ZERO;
        mh_wdata       = 128'h0;
        mh_wen         = 16'h0000;
        mh_wen_tag     = 4'h0;
        mh_wen_valid   = 4'h0;
        mh_wen_dirty   = 4'h0;
        mh_tag_w       = {(4*TAG_BIT){1'b0}};
        mh_valid_w     = 4'h0;
        mh_dirty_w     = 4'h0;
        mh_wen_history = 1'b0;
        mh_history_w   = 3'b000;
        mem_req        = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = 32'h0000_0000;
        mem_wdata      = 32'h0000_0000;
        mem_wstrb      = 4'h0;
        case (state_r)
            ST_IDLE: begin
                handler_fin = !handler_req;
                if (handler_req) begin
                    state_s = handler_cached ? ST_LOOKUP : ST_UNC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                mh_blkidx = blkidx_r;
                cnt_s     = CNT_ZERO;
                state_s   = vdirty_s ? ST_WB : ST_REFILL;
            end
            ST_WB: begin
                mh_blkidx = blkidx_r;
                mh_wrdidx = cnt_r;
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_wstrb = 4'hF;
                mem_addr  = {vtag_r, blkidx_r, cnt_r, 2'b00};
                mem_wdata = wb_word_s;
                if (mem_ack && cnt_r == CNT_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_REFILL;
                end else if (mem_ack) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_REFILL: begin
                mh_blkidx = blkidx_r;
                mh_wrdidx = cnt_r;
                mem_req   = 1'b1;
                mem_addr  = {paddr_r[31:WRDIDX_BIT+2], cnt_r, 2'b00};
                if (mem_ack) begin
                    mh_wen   = {{4{victim_r[3]}}, {4{victim_r[2]}},
                                {4{victim_r[1]}}, {4{victim_r[0]}}};
                    mh_wdata = {4{mem_rdata}};
                    cnt_s    = cnt_r + CNT_ONE;
                    state_s  = (cnt_r == CNT_LAST) ? ST_META : ST_REFILL;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_META: begin
                mh_blkidx      = blkidx_r;
                mh_wen_tag     = victim_r;
                mh_wen_valid   = victim_r;
                mh_wen_dirty   = victim_r;
                mh_tag_w       = {4{paddr_r[31:32-TAG_BIT]}};
                mh_valid_w     = 4'hF;
                mh_dirty_w     = 4'h0;
                mh_wen_history = 1'b1;
                mh_history_w   = plru_update(cache_history_r, victim_r);
                state_s        = ST_DONE;
            end
            ST_DONE: begin
                mh_blkidx   = blkidx_r;
                handler_fin = 1'b1;
                state_s     = ST_IDLE;
            end
            ST_UNC: begin
                mh_blkidx = blkidx_r;
                mem_req   = 1'b1;
                mem_wr    = w_r;
                mem_addr  = paddr_r;
                mem_wdata = w_r ? wdata_r : 32'h0000_0000;
                mem_wstrb = w_r ? wen_r : 4'h0;
                if (mem_ack) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_UNC;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_cache4way_miss_handler.sv
// Directed bench for cache4way_miss_handler: behavioural cache arrays and a
// word memory whose read data equals the address (or a fixed override).
module tb_cache4way_miss_handler;
    import cache4way_miss_handler_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  handler_req, handler_cached, handler_w;
    logic [31:0]           handler_paddr, handler_wdata;
    logic [BLKIDX_BIT-1:0] handler_blkidx;
    logic [3:0]            handler_wen;
    logic                  handler_fin;
    logic [31:0]           handler_rdata;
    logic [BLKIDX_BIT-1:0] mh_blkidx;
    logic [WRDIDX_BIT-1:0] mh_wrdidx;
    logic [127:0]          mh_wdata, cache_rdata;
    logic [15:0]           mh_wen;
    logic [4*TAG_BIT-1:0]  cache_tag_r, mh_tag_w;
    logic [3:0]            cache_valid_r, cache_dirty_r;
    logic [2:0]            cache_history_r, mh_history_w;
    logic [3:0]            mh_wen_tag, mh_wen_valid, mh_wen_dirty, mh_valid_w, mh_dirty_w;
    logic                  mh_wen_history;
    logic                  mem_req, mem_wr, mem_ack;
    logic [31:0]           mem_addr, mem_wdata, mem_rdata;
    logic [3:0]            mem_wstrb;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural cache arrays
    logic [31:0]        data_m [16][16][4];
    logic [TAG_BIT-1:0] tag_m  [16][4];
    logic [3:0]         valid_m [16];
    logic [3:0]         dirty_m [16];
    logic [2:0]         hist_m  [16];
    int                 wr_cnt = 0;
    int                 en_cnt = 0;

    // Preload request for one set
    logic               cfg_load = 1'b0;
    logic [3:0]         cfg_set, cfg_valid, cfg_dirty;
    logic [2:0]         cfg_hist;
    logic [TAG_BIT-1:0] cfg_tag [4];
    logic [31:0]        cfg_base [4];

    // Memory side
    logic ack_rand = 1'b0;
    logic rd_ovr   = 1'b0;
    txn_t log_q[$];
    logic pend = 1'b0;
    txn_t pend_t, cur_t;
    int   hold_cnt = 0;
    int   hold_err = 0;

    cache4way_miss_handler dut (
        .clk(clk), .rst(rst),
        .handler_req(handler_req), .handler_cached(handler_cached), .handler_w(handler_w),
        .handler_paddr(handler_paddr), .handler_blkidx(handler_blkidx),
        .handler_wdata(handler_wdata), .handler_wen(handler_wen),
        .handler_fin(handler_fin), .handler_rdata(handler_rdata),
        .mh_blkidx(mh_blkidx), .mh_wrdidx(mh_wrdidx), .mh_wdata(mh_wdata), .mh_wen(mh_wen),
        .cache_rdata(cache_rdata), .cache_tag_r(cache_tag_r), .cache_valid_r(cache_valid_r),
        .cache_dirty_r(cache_dirty_r), .cache_history_r(cache_history_r),
        .mh_wen_tag(mh_wen_tag), .mh_wen_valid(mh_wen_valid), .mh_wen_dirty(mh_wen_dirty),
        .mh_tag_w(mh_tag_w), .mh_valid_w(mh_valid_w), .mh_dirty_w(mh_dirty_w),
        .mh_wen_history(mh_wen_history), .mh_history_w(mh_history_w),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Combinational array read at the handler's select
    always_comb begin
        cache_rdata     = 128'h0;
        cache_tag_r     = {(4*TAG_BIT){1'b0}};
        for (int w = 0; w < 4; w++) begin
            cache_rdata[32*w +: 32]          = data_m[mh_blkidx][mh_wrdidx][w];
            cache_tag_r[TAG_BIT*w +: TAG_BIT] = tag_m[mh_blkidx][w];
        end
        cache_valid_r   = valid_m[mh_blkidx];
        cache_dirty_r   = dirty_m[mh_blkidx];
        cache_history_r = hist_m[mh_blkidx];
    end

    // Array writes commit at the clock edge; preload shares the same process
    always @(posedge clk) begin
        if (cfg_load) begin
            valid_m[cfg_set] <= cfg_valid;
            dirty_m[cfg_set] <= cfg_dirty;
            hist_m[cfg_set]  <= cfg_hist;
            for (int w = 0; w < 4; w++) begin
                tag_m[cfg_set][w] <= cfg_tag[w];
                for (int i = 0; i < 16; i++) data_m[cfg_set][i][w] <= cfg_base[w] + 32'(i);
            end
        end
        for (int w = 0; w < 4; w++) begin
            if (mh_wen[4*w +: 4] != 4'h0) data_m[mh_blkidx][mh_wrdidx][w] <= mh_wdata[32*w +: 32];
            if (mh_wen_tag[w])   tag_m[mh_blkidx][w]   <= mh_tag_w[TAG_BIT*w +: TAG_BIT];
            if (mh_wen_valid[w]) valid_m[mh_blkidx][w] <= mh_valid_w[w];
            if (mh_wen_dirty[w]) dirty_m[mh_blkidx][w] <= mh_dirty_w[w];
        end
        if (mh_wen_history) hist_m[mh_blkidx] <= mh_history_w;
        if (mh_wen != 16'h0) wr_cnt <= wr_cnt + 1;
        if ((mh_wen != 16'h0) || (mh_wen_tag != 4'h0) || (mh_wen_valid != 4'h0) ||
            (mh_wen_dirty != 4'h0) || mh_wen_history) en_cnt <= en_cnt + 1;
    end

    assign mem_rdata = rd_ovr ? 32'h1234_5678 : mem_addr;
    assign cur_t     = {mem_addr, mem_wr, mem_wdata, mem_wstrb};

    // Memory acknowledge: tied high or 30% random
    always @(negedge clk) begin
        mem_ack = ack_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    // Completed memory transactions and request-hold tracking
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            if (mem_req && mem_ack) log_q.push_back(cur_t);
            if (pend) begin
                hold_cnt <= hold_cnt + 1;
                if (!mem_req || cur_t != pend_t) hold_err <= hold_err + 1;
            end
            pend   <= mem_req && !mem_ack;
            pend_t <= cur_t;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] set, input logic [3:0] v, input logic [3:0] d,
                           input logic [2:0] h, input logic [TAG_BIT-1:0] tbase,
                           input logic [31:0] dbase);
        @(negedge clk);
        cfg_set = set; cfg_valid = v; cfg_dirty = d; cfg_hist = h;
        for (int w = 0; w < 4; w++) begin
            cfg_tag[w]  = tbase + TAG_BIT'(w);
            cfg_base[w] = dbase + (32'(w) << 24);
        end
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Issue one request; cyc = negedges from accept until handler_fin (bounded)
    task automatic run_req(input logic cached, input logic w, input logic [31:0] paddr,
                           input logic [3:0] blk, input logic [31:0] wd,
                           input logic [3:0] wen, output int cyc);
        @(negedge clk);
        handler_req = 1'b1; handler_cached = cached; handler_w = w;
        handler_paddr = paddr; handler_blkidx = blk; handler_wdata = wd; handler_wen = wen;
        @(negedge clk);
        handler_req = 1'b0;
        cyc = 1;
        while (!handler_fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    localparam logic [TAG_BIT-1:0] T1  = 22'h2ABCD1;
    localparam logic [TAG_BIT-1:0] OLD = 22'h011110;
    localparam logic [TAG_BIT-1:0] NEW = 22'h3C0FFE;
    localparam logic [TAG_BIT-1:0] T3  = 22'h012345;
    localparam logic [TAG_BIT-1:0] T6  = 22'h0F0F0F;

    initial begin
        int   cyc, l0, w0, e0;
        txn_t e;
        logic [31:0] a;

        rst = 1'b1; handler_req = 1'b0; handler_cached = 1'b0; handler_w = 1'b0;
        handler_paddr = 32'h0; handler_blkidx = 4'h0; handler_wdata = 32'h0; handler_wen = 4'h0;
        cfg_set = 4'h0; cfg_valid = 4'h0; cfg_dirty = 4'h0; cfg_hist = 3'b000;
        for (int s = 0; s < 16; s++) preload(4'(s), 4'h0, 4'h0, 3'b000, 22'h0, 32'h0);

        // Reset state
        check("rst_fin_idle", {31'h0, handler_fin}, 128'h1);
        check("rst_mem_req", {31'h0, mem_req}, 128'h0);
        check("rst_mh_wen", {112'h0, mh_wen}, 128'h0);
        check("rst_rdata", {96'h0, handler_rdata}, 128'h0);
        handler_req = 1'b1; #1;
        check("rst_fin_req", {31'h0, handler_fin}, 128'h0);
        handler_req = 1'b0;
        @(negedge clk); rst = 1'b0;

        // 1: clean miss into an all-invalid set
        preload(4'd3, 4'h0, 4'h0, 3'b111, 22'h0, 32'h0);
        l0 = log_q.size();
        run_req(1'b1, 1'b0, {T1, 4'd3, 4'd5, 2'b00}, 4'd3, 32'h0, 4'h0, cyc);
        check("t1_cycles", 128'(cyc), 128'd19);
        check("t1_ntxn", 128'(log_q.size() - l0), 128'd16);
        for (int i = 0; i < 16; i++) begin
            e = log_q[l0 + i];
            a = {T1, 4'd3, 4'(i), 2'b00};
            check($sformatf("t1_word%0d", i), {e.addr, e.wr, e.wstrb, data_m[3][i][0]},
                  {a, 1'b0, 4'h0, a});
        end
        check("t1_tag", 128'(tag_m[3][0]), 128'(T1));
        check("t1_meta", {valid_m[3], dirty_m[3], hist_m[3]}, {4'b0001, 4'b0000, 3'b100});

        // 2: full set, history 001 picks dirty way1 -> write-back then refill
        preload(4'd5, 4'hF, 4'b0010, 3'b001, OLD, 32'hA000_0000);
        l0 = log_q.size();
        run_req(1'b1, 1'b0, {NEW, 4'd5, 4'd2, 2'b00}, 4'd5, 32'h0, 4'h0, cyc);
        check("t2_cycles", 128'(cyc), 128'd35);
        check("t2_ntxn", 128'(log_q.size() - l0), 128'd32);
        for (int i = 0; i < 16; i++) begin
            e = log_q[l0 + i];
            check($sformatf("t2_wb%0d", i), e,
                  {OLD + 22'd1, 4'd5, 4'(i), 2'b00, 1'b1, 32'hA100_0000 + 32'(i), 4'hF});
            e = log_q[l0 + 16 + i];
            a = {NEW, 4'd5, 4'(i), 2'b00};
            check($sformatf("t2_rf%0d", i), {e.addr, e.wr, data_m[5][i][1]}, {a, 1'b0, a});
        end
        check("t2_way0_kept", {96'h0, data_m[5][3][0]}, 128'hA000_0003);
        check("t2_tag", 128'(tag_m[5][1]), 128'(NEW));
        check("t2_meta", {valid_m[5], dirty_m[5], hist_m[5]}, {4'hF, 4'h0, 3'b010});

        // 3: random acknowledge, way0 valid and dirty -> lowest invalid way1, no write-back
        preload(4'd7, 4'b0001, 4'b0001, 3'b000, 22'h0, 32'h0);
        ack_rand = 1'b1;
        l0 = log_q.size();
        run_req(1'b1, 1'b0, {T3, 4'd7, 4'd0, 2'b00}, 4'd7, 32'h0, 4'h0, cyc);
        ack_rand = 1'b0;
        check("t3_ntxn", 128'(log_q.size() - l0), 128'd16);
        for (int i = 0; i < 16; i++) begin
            e = log_q[l0 + i];
            a = {T3, 4'd7, 4'(i), 2'b00};
            check($sformatf("t3_word%0d", i), {e.addr, e.wr, data_m[7][i][1]}, {a, 1'b0, a});
        end
        check("t3_meta", {valid_m[7], dirty_m[7], hist_m[7]}, {4'b0011, 4'b0001, 3'b010});
        check("t3_hold_err", 128'(hold_err), 128'd0);
        check("t3_hold_seen", 128'(hold_cnt > 0), 128'd1);

        // 5: uncached read
        rd_ovr = 1'b1;
        e0 = en_cnt; l0 = log_q.size();
        run_req(1'b0, 1'b0, 32'h2000_0008, 4'd0, 32'h0, 4'hF, cyc);
        rd_ovr = 1'b0;
        check("t5_cycles", 128'(cyc), 128'd2);
        check("t5_rdata", {96'h0, handler_rdata}, 128'h1234_5678);
        e = log_q[l0];
        check("t5_txn", {log_q.size() - l0, e.addr, e.wr, e.wstrb}, {32'd1, 32'h2000_0008, 1'b0, 4'h0});

        // 4: uncached write; no array enables, read data held
        l0 = log_q.size();
        run_req(1'b0, 1'b1, 32'h1000_0104, 4'd0, 32'hDEAD_BEEF, 4'b0011, cyc);
        check("t4_cycles", 128'(cyc), 128'd2);
        check("t4_ntxn", 128'(log_q.size() - l0), 128'd1);
        check("t4_txn", log_q[l0], {32'h1000_0104, 1'b1, 32'hDEAD_BEEF, 4'b0011});
        check("t4_no_mh_en", 128'(en_cnt - e0), 128'd0);
        check("t4_rdata_held", {96'h0, handler_rdata}, 128'h1234_5678);

        // 6: reset in refill word 7, then a full retry
        preload(4'd9, 4'h0, 4'h0, 3'b000, 22'h0, 32'h0);
        w0 = wr_cnt;
        @(negedge clk);
        handler_req = 1'b1; handler_cached = 1'b1; handler_w = 1'b0;
        handler_paddr = {T6, 4'd9, 4'd0, 2'b00}; handler_blkidx = 4'd9;
        @(negedge clk);
        handler_req = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_word7_addr", {96'h0, mem_addr}, {96'h0, T6, 4'd9, 4'd7, 2'b00});
        check("t6_writes_before", 128'(wr_cnt - w0), 128'd7);
        rst = 1'b1; #1;
        check("t6_rst_outputs", {mem_req, mh_wen, handler_fin}, {1'b0, 16'h0, 1'b1});
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("t6_writes_after", 128'(wr_cnt - w0), 128'd7);
        check("t6_valid_after", 128'(valid_m[9]), 128'd0);
        run_req(1'b1, 1'b0, {T6, 4'd9, 4'd0, 2'b00}, 4'd9, 32'h0, 4'h0, cyc);
        check("t6_retry_cycles", 128'(cyc), 128'd19);
        check("t6_retry_meta", {valid_m[9], tag_m[9][0], data_m[9][15][0]},
              {4'b0001, T6, T6, 4'd9, 4'd15, 2'b00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
